part_1_init_put_ctrl: RTL and testbench

//  Initiator-side put controller: the transmit end of the mission-clock data exchange with the target partition.
//  - Detects rising edges of mission clocks, sampled in the clk_i domain.
//  - Captures the per-event data vector and freezes that mission clock.
//  - Sends each captured vector to the fringe bridge over a req/ack handshake, then releases the freeze.
//  - A watchdog flags a bridge that never acknowledges.

---
 rtl/part_cs_put_pkg.sv | 21 ++
 rtl/part_1_init_put_ctrl_arb.sv | 57 +++++
 rtl/part_1_init_put_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_part_1_init_put_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/part_cs_put_pkg.sv
// Shared types and constants for the initiator-side put controller.
package part_cs_put_pkg;

   // Default geometry of the exchange.
   localparam int N_EV_DEF     = 4;
   localparam int DW_DEF       = 9;
   localparam int WDOG_MAX_DEF = 100;

   // Width of an event index for the default geometry.
   localparam int EVW = $clog2(N_EV_DEF);

   // Saturation value of the drop counter.
   localparam logic [7:0] DROP_MAX = 8'hFF;

   // Controller states. ERR is absorbing until reset.
   typedef logic [1:0] put_state_e;
   localparam put_state_e ST_IDLE = 2'd0;
   localparam put_state_e ST_REQ  = 2'd1;
   localparam put_state_e ST_ERR  = 2'd2;

endpackage : part_cs_put_pkg

// File: rtl/part_1_init_put_ctrl_arb.sv
// Round-robin arbiter: the search starts one past the last index that
// completed a successful transfer. The pointer moves only when told to.
module cs_rr_arb
   import part_cs_put_pkg::*;
#(
   parameter int N = N_EV_DEF
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic [N-1:0]         req_i,
   input  logic                 adv_i,
   input  logic [$clog2(N)-1:0] adv_idx_i,
   output logic [N-1:0]         gnt_o,
   output logic [$clog2(N)-1:0] idx_o,
   output logic                 valid_o
);

   localparam int IW = $clog2(N);

   logic [IW-1:0] ptr_q, ptr_d;

   // Search requesters in rotating order, starting after the pointer.
   always_comb begin : p_search
      int   j;
      logic found;
      // NOTE: every signal written here gets a default first, so no path
      //       through the block leaves a value unassigned (no latch).
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      j     = 0;
      for (int i = 0; i < N; i++) begin
         j = int'(ptr_q) + 1 + i;
         if (j >= N) j = j - N;
         if (!found && req_i[j]) begin
            found    = 1'b1;
            gnt_o[j] = 1'b1;
            idx_o    = IW'(j);
         end
      end
      valid_o = found;
   end

   // Pointer follows the index that just completed successfully.
   always_comb begin
      ptr_d = adv_i ? adv_idx_i : ptr_q;
   end

   // Pointer register with synchronous reset.
   always_ff @(posedge clk_i) begin
      // NOTE: sequential state is updated with non-blocking assignments only,
      //       so every flop samples the pre-edge values of its inputs.
      if (!rst_n_i) ptr_q <= '0;
      else          ptr_q <= ptr_d;
   end

endmodule : cs_rr_arb

// File: rtl/part_1_init_put_ctrl.sv
// Initiator-side put controller: captures mission-clock events, freezes the
// event clock, sends the payload over a req/ack handshake and releases it.
module part_1_init_put_ctrl
   import part_cs_put_pkg::*;
#(
   parameter int N_EV     = N_EV_DEF,
   parameter int DW       = DW_DEF,
   parameter int WDOG_MAX = WDOG_MAX_DEF
) (
   input  logic                    clk_i,
   input  logic                    rst_n_i,
   input  logic [N_EV-1:0]         clk_ev_i,
   input  logic [N_EV*DW-1:0]      ev_data_i,
   output logic [N_EV-1:0]         freeze_clk_o,
   output logic                    put_req_o,
   output logic [$clog2(N_EV)-1:0] put_ev_o,
   output logic [DW-1:0]           put_data_o,
   input  logic                    put_ack_i,
   input  logic                    put_err_i,
   output logic                    wdog_err_o,
   output logic                    busy_o,
   output logic [7:0]              drop_cnt_o
);

   localparam int EW = $clog2(N_EV);
   localparam int WW = $clog2(WDOG_MAX);

   // State
   put_state_e     state_q, state_d;
   logic [N_EV-1:0] pending_q, pending_d;
   logic [N_EV-1:0] ev_prev_q, ev_prev_d;
   logic [N_EV-1:0] skip_q, skip_d;
   logic [DW-1:0]   slot_data_q [N_EV];
   logic [DW-1:0]   slot_data_d [N_EV];
   logic            put_req_q, put_req_d;
   logic [EW-1:0]   put_ev_q, put_ev_d;
   logic [DW-1:0]   put_data_q, put_data_d;
   logic [WW-1:0]   wdog_q, wdog_d;
   logic            wdog_err_q, wdog_err_d;
   logic [7:0]      drop_cnt_q, drop_cnt_d;

   // Combinational helpers
   logic [N_EV-1:0] edge_ev, clr_mask, pend_kept, cap, drop;
   logic [N_EV-1:0] arb_req, arb_masked, arb_gnt;
   logic [EW-1:0]   arb_idx;
   logic            arb_valid, arb_adv;
   logic            ack_ok;
   logic [DW-1:0]   gnt_data;

   // A slot that just failed is skipped while any other slot waits, so a
   // failing transfer never starves the rest; alone, it retries at once.
   always_comb begin
      arb_masked = pending_q & ~skip_q;
      arb_req    = (|arb_masked) ? arb_masked : pending_q;
   end

   cs_rr_arb #(.N(N_EV)) u_arb (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .req_i     (arb_req),
      .adv_i     (arb_adv),
      .adv_idx_i (put_ev_q),
      .gnt_o     (arb_gnt),
      .idx_o     (arb_idx),
      .valid_o   (arb_valid)
   );

   // Payload of the granted slot, selected by the one-hot grant.
   always_comb begin
      gnt_data = '0;
      for (int k = 0; k < N_EV; k++) begin
         if (arb_gnt[k]) gnt_data = slot_data_q[k];
      end
   end

   // Edge detect, slot capture and drop counting. A successful ack clears
   // its slot before new edges are applied, so ack+edge recaptures cleanly.
   always_comb begin
      int sum;
      ack_ok    = put_req_q & put_ack_i & ~put_err_i;
      edge_ev   = clk_ev_i & ~ev_prev_q;
      ev_prev_d = clk_ev_i;
      clr_mask  = '0;
      if (ack_ok) clr_mask[put_ev_q] = 1'b1;
      pend_kept = pending_q & ~clr_mask;
      cap       = edge_ev & ~pend_kept;
      drop      = edge_ev & pend_kept;
      pending_d = pend_kept | cap;
      for (int k = 0; k < N_EV; k++) begin
         slot_data_d[k] = cap[k] ? ev_data_i[k*DW +: DW] : slot_data_q[k];
      end
      sum = int'(drop_cnt_q);
      for (int k = 0; k < N_EV; k++) begin
         sum = sum + int'(drop[k]);
      end
      drop_cnt_d = (sum > int'(DROP_MAX)) ? DROP_MAX : 8'(sum);
   end

   // Request FSM with watchdog.
   always_comb begin
      state_d    = state_q;
      put_req_d  = put_req_q;
      put_ev_d   = put_ev_q;
      put_data_d = put_data_q;
      wdog_d     = wdog_q;
      wdog_err_d = wdog_err_q;
      skip_d     = skip_q;
      arb_adv    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (arb_valid) begin
               state_d    = ST_REQ;
               put_req_d  = 1'b1;
               put_ev_d   = arb_idx;
               put_data_d = gnt_data;
               wdog_d     = '0;
            end
         end
         ST_REQ: begin
            if (put_ack_i) begin
               state_d   = ST_IDLE;
               put_req_d = 1'b0;
               if (put_err_i) begin
                  skip_d[put_ev_q] = 1'b1;
               end else begin
                  skip_d  = '0;
                  arb_adv = 1'b1;
               end
            end else if (wdog_q == WW'(WDOG_MAX - 1)) begin
               state_d    = ST_ERR;
               put_req_d  = 1'b0;
               wdog_err_d = 1'b1;
            end else begin
               wdog_d = wdog_q + WW'(1);
            end
         end
         default: begin
            // ERR: hold everything until reset.
            state_d = ST_ERR;
         end
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q    <= ST_IDLE;
         pending_q  <= '0;
         ev_prev_q  <= '0;
         skip_q     <= '0;
         put_req_q  <= 1'b0;
         put_ev_q   <= '0;
         put_data_q <= '0;
         wdog_q     <= '0;
         wdog_err_q <= 1'b0;
         drop_cnt_q <= '0;
         // NOTE: the slot array is a handful of flops, not a RAM, so it can
         //       be cleared on reset like any other register.
         for (int k = 0; k < N_EV; k++) slot_data_q[k] <= '0;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         ev_prev_q  <= ev_prev_d;
         skip_q     <= skip_d;
         put_req_q  <= put_req_d;
         put_ev_q   <= put_ev_d;
         put_data_q <= put_data_d;
         wdog_q     <= wdog_d;
         wdog_err_q <= wdog_err_d;
         drop_cnt_q <= drop_cnt_d;
         for (int k = 0; k < N_EV; k++) slot_data_q[k] <= slot_data_d[k];
      end
   end

   // Outputs. A mission clock stays frozen exactly while its slot is pending.
   assign freeze_clk_o = pending_q;
   assign put_req_o    = put_req_q;
   assign put_ev_o     = put_ev_q;
   assign put_data_o   = put_data_q;
   assign wdog_err_o   = wdog_err_q;
   assign drop_cnt_o   = drop_cnt_q;
   assign busy_o       = (|pending_q) | put_req_q;

endmodule : part_1_init_put_ctrl

// File: tb/tb_part_1_init_put_ctrl.sv
// Self-checking bench: directed stimulus pushes expected requests into a
// scoreboard queue; a monitor pops and compares on each new request.
module tb_part_1_init_put_ctrl;
   import part_cs_put_pkg::*;

   localparam int N_EV = 4;
   localparam int DW   = 9;

   typedef struct packed {
      logic [EVW-1:0] ev;
      logic [DW-1:0]  data;
   } exp_t;

   logic               clk_i = 1'b0;
   logic               rst_n_i;
   logic [N_EV-1:0]    clk_ev_i;
   logic [N_EV*DW-1:0] ev_data_i;
   logic [N_EV-1:0]    freeze_clk_o;
   logic               put_req_o;
   logic [EVW-1:0]     put_ev_o;
   logic [DW-1:0]      put_data_o;
   logic               put_ack_i;
   logic               put_err_i;
   logic               wdog_err_o;
   logic               busy_o;
   logic [7:0]         drop_cnt_o;

   int   n_cmp  = 0;
   int   n_fail = 0;
   exp_t exp_q[$];
   exp_t exp_e;
   logic req_prev = 1'b0;
   int   ncyc;

   part_1_init_put_ctrl #(.N_EV(N_EV), .DW(DW), .WDOG_MAX(100)) dut (
      .clk_i        (clk_i),
      .rst_n_i      (rst_n_i),
      .clk_ev_i     (clk_ev_i),
      .ev_data_i    (ev_data_i),
      .freeze_clk_o (freeze_clk_o),
      .put_req_o    (put_req_o),
      .put_ev_o     (put_ev_o),
      .put_data_o   (put_data_o),
      .put_ack_i    (put_ack_i),
      .put_err_i    (put_err_i),
      .wdog_err_o   (wdog_err_o),
      .busy_o       (busy_o),
      .drop_cnt_o   (drop_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   // Scoreboard monitor: compare every new request against the queue head.
   always @(negedge clk_i) begin
      if (put_req_o && !req_prev) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_req: got ev=%0d data=0x%0h, required no request",
                     put_ev_o, put_data_o);
         end else begin
            exp_e = exp_q.pop_front();
            check("req_ev", 32'(put_ev_o), 32'(exp_e.ev));
            check("req_data", 32'(put_data_o), 32'(exp_e.data));
         end
      end
      req_prev = put_req_o;
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_slot(input int k, input logic [DW-1:0] v);
      ev_data_i[k*DW +: DW] = v;
   endtask

   task automatic expect_req(input logic [EVW-1:0] ev, input logic [DW-1:0] d);
      exp_t e;
      e.ev   = ev;
      e.data = d;
      exp_q.push_back(e);
   endtask

   // One-cycle high pulse followed by a low cycle; returns two cycles later.
   task automatic pulse_ev(input logic [N_EV-1:0] mask);
      clk_ev_i = mask;
      tick();
      clk_ev_i = '0;
      tick();
   endtask

   task automatic wait_req();
      int n = 0;
      while (!put_req_o && n < 200) begin
         tick();
         n++;
      end
      check("req_within_budget", 32'(put_req_o), 32'd1);
   endtask

   task automatic do_ack(input int dly, input logic err);
      wait_req();
      repeat (dly) tick();
      put_ack_i = 1'b1;
      put_err_i = err;
      tick();
      put_ack_i = 1'b0;
      put_err_i = 1'b0;
   endtask

   function automatic logic [31:0] all_outs();
      return 32'({freeze_clk_o, put_req_o, put_ev_o, put_data_o, wdog_err_o, busy_o, drop_cnt_o});
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got no finish, required finish");
      $fatal(1);
   end

   initial begin
      rst_n_i   = 1'b0;
      clk_ev_i  = '0;
      ev_data_i = '0;
      put_ack_i = 1'b0;
      put_err_i = 1'b0;
      repeat (3) tick();
      check("reset_outputs", all_outs(), 32'd0);
      rst_n_i = 1'b1;
      tick();

      // 1. Single edge on event 0, ack three cycles after the request.
      set_slot(0, 9'h1A5);
      expect_req(2'd0, 9'h1A5);
      clk_ev_i = 4'b0001;
      tick();
      clk_ev_i = '0;
      check("t1_freeze_t1", 32'(freeze_clk_o), 32'h1);
      check("t1_req_t1", 32'(put_req_o), 32'd0);
      tick();
      check("t1_req_t2", 32'(put_req_o), 32'd1);
      repeat (3) tick();
      put_ack_i = 1'b1;
      tick();
      put_ack_i = 1'b0;
      check("t1_freeze_released", 32'(freeze_clk_o), 32'h0);
      check("t1_req_dropped", 32'(put_req_o), 32'd0);
      // Stray ack while idle is ignored.
      put_ack_i = 1'b1;
      tick();
      put_ack_i = 1'b0;
      tick();
      check("t1_stray_ack_idle", 32'({put_req_o, busy_o}), 32'd0);

      // 2. Simultaneous edges on 1, 2, 3; then 0 and 1 together (0 first).
      set_slot(1, 9'h011);
      set_slot(2, 9'h122);
      set_slot(3, 9'h033);
      expect_req(2'd1, 9'h011);
      expect_req(2'd2, 9'h122);
      expect_req(2'd3, 9'h033);
      pulse_ev(4'b1110);
      check("t2_freeze_all", 32'(freeze_clk_o), 32'hE);
      do_ack(1, 1'b0);
      do_ack(1, 1'b0);
      do_ack(1, 1'b0);
      set_slot(0, 9'h0F0);
      set_slot(1, 9'h10F);
      expect_req(2'd0, 9'h0F0);
      expect_req(2'd1, 9'h10F);
      pulse_ev(4'b0011);
      do_ack(1, 1'b0);
      do_ack(1, 1'b0);
      tick();
      check("t2_idle_after", 32'({freeze_clk_o, busy_o}), 32'd0);

      // 3. Second edge on event 2 while pending is dropped.
      set_slot(2, 9'h0AB);
      expect_req(2'd2, 9'h0AB);
      clk_ev_i = 4'b0100;
      tick();
      clk_ev_i = '0;
      set_slot(2, 9'h155);
      tick();
      clk_ev_i = 4'b0100;
      tick();
      clk_ev_i = '0;
      tick();
      check("t3_drop_one", 32'(drop_cnt_o), 32'd1);
      check("t3_data_stable", 32'(put_data_o), 32'h0AB);
      do_ack(2, 1'b0);

      // 4. Error ack on event 1 while 3 pends: 3 next, then 1 resent.
      set_slot(0, 9'h0C3);
      expect_req(2'd0, 9'h0C3);
      pulse_ev(4'b0001);
      do_ack(1, 1'b0);
      set_slot(1, 9'h1E1);
      set_slot(3, 9'h1D3);
      expect_req(2'd1, 9'h1E1);
      expect_req(2'd3, 9'h1D3);
      expect_req(2'd1, 9'h1E1);
      pulse_ev(4'b1010);
      do_ack(2, 1'b1);
      check("t4_freeze_kept", 32'(freeze_clk_o), 32'hA);
      do_ack(1, 1'b0);
      do_ack(1, 1'b0);
      tick();
      check("t4_idle_after", 32'({freeze_clk_o, busy_o}), 32'd0);

      // 6a. Ack and new edge on event 0 in the same cycle.
      set_slot(0, 9'h0A0);
      expect_req(2'd0, 9'h0A0);
      expect_req(2'd0, 9'h05F);
      pulse_ev(4'b0001);
      wait_req();
      tick();
      put_ack_i = 1'b1;
      clk_ev_i  = 4'b0001;
      set_slot(0, 9'h05F);
      tick();
      put_ack_i = 1'b0;
      clk_ev_i  = '0;
      check("t6_pending_kept", 32'(freeze_clk_o), 32'h1);
      check("t6_no_drop", 32'(drop_cnt_o), 32'd1);
      do_ack(1, 1'b0);

      // 6b. Reset asserted mid-request.
      set_slot(2, 9'h111);
      expect_req(2'd2, 9'h111);
      pulse_ev(4'b0100);
      wait_req();
      tick();
      rst_n_i = 1'b0;
      tick();
      check("t6_reset_mid_req", all_outs(), 32'd0);
      rst_n_i = 1'b1;
      repeat (5) tick();
      check("t6_no_stray_req", 32'({put_req_o, busy_o}), 32'd0);

      // 5. Watchdog: no ack for event 3.
      set_slot(3, 9'h1FF);
      expect_req(2'd3, 9'h1FF);
      pulse_ev(4'b1000);
      wait_req();
      ncyc = 0;
      while (put_req_o && ncyc < 200) begin
         tick();
         ncyc++;
      end
      check("t5_wdog_cycles", 32'(ncyc), 32'd100);
      check("t5_wdog_err", 32'(wdog_err_o), 32'd1);
      // Drops keep counting in ERR and saturate.
      repeat (10) pulse_ev(4'b1000);
      check("t5_drop_10", 32'(drop_cnt_o), 32'd10);
      repeat (290) pulse_ev(4'b1000);
      check("t5_drop_sat", 32'(drop_cnt_o), 32'd255);
      pulse_ev(4'b0010);
      check("t5_err_capture", 32'(freeze_clk_o), 32'hA);
      check("t5_err_held", 32'({put_req_o, wdog_err_o, busy_o}), 32'b011);
      rst_n_i = 1'b0;
      tick();
      check("t5_reset_clears", all_outs(), 32'd0);
      rst_n_i = 1'b1;
      repeat (3) tick();

      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule : tb_part_1_init_put_ctrl
